force_reg_bank: RTL
===================

FORCE_REG_BANK -- requirements
Module: force_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per channel register.
REQ-002 SHALL have parameter CH, default 4, meaning number of channels (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, meaning width of the force-duration counter.
REQ-004 SHALL have parameter RST_VAL, default 0, meaning the WIDTH-bit reset value of every channel register.
REQ-005 SHALL have parameter REL_MODE, default 0, meaning 0 = keep forced value on release, 1 = restore captured value on release.
REQ-006 SHALL derive local CH_W = clog2(CH), minimum 1.
REQ-007 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port en  input  CH  per-channel capture enable.
REQ-010 SHALL have port d  input  CH*WIDTH  capture data, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port frc_req  input  1  force request, sampled on the clock edge.
REQ-012 SHALL have port frc_ch  input  CH_W  force target channel.
REQ-013 SHALL have port frc_mask  input  WIDTH  bits to override (1 = forced).
REQ-014 SHALL have port frc_val  input  WIDTH  override value.
REQ-015 SHALL have port frc_len  input  CNT_W  force duration in cycles, 0 = until released.
REQ-016 SHALL have port rel_req  input  1  release request.
REQ-017 SHALL have port rel_ch  input  CH_W  release target channel.
REQ-018 SHALL have port q  output  CH*WIDTH  per-channel visible value, same packing as d.
REQ-019 SHALL have port frc_act  output  CH  per-channel force-active flag.
REQ-020 SHALL have port frc_done  output  CH  one-cycle pulse on timed-force expiry.

Function
REQ-021 SHALL keep per channel: capture reg cap, mask reg msk, value reg fv, counter cnt, flag act.
REQ-022 SHALL drive q[i] = (msk & fv) | (~msk & cap), combinational from registered state; frc_act[i] = act[i].
REQ-023 SHALL load cap[i] <= d[i] on an edge with en[i]=1, whether or not channel i is forced.
REQ-024 SHALL, on an edge with frc_req=1 and frc_ch<CH, load msk<=frc_mask, fv<=frc_val, cnt<=frc_len, act<=|frc_mask; q reflects it the next cycle (1-edge latency).
REQ-025 SHALL ignore frc_req with frc_ch>=CH and rel_req with rel_ch>=CH (no state change).
REQ-026 SHALL treat a force on an already-forced channel as full replacement of msk, fv and cnt.
REQ-027 SHALL, on release of an active channel, clear msk, cnt and act at that edge.
REQ-028 SHALL, when REL_MODE=0, load cap <= current q at the release edge, overriding en/d for that edge; q therefore stays unchanged across release.
REQ-029 SHALL, when REL_MODE=1, leave cap to normal en/d capture at the release edge.
REQ-030 SHALL treat rel_req on an inactive channel as no-op (cap untouched beyond en/d).
REQ-031 SHALL give force priority when frc_req and rel_req target the same channel on one edge; different channels are processed independently.
REQ-032 SHALL, while act=1 and cnt>1, decrement cnt by 1 per edge; with cnt=1 perform a release per REQ-027..029 and assert frc_done[i] for exactly the following cycle.
REQ-033 SHALL never decrement or expire when cnt=0 (indefinite force); a new force arriving on the expiry edge wins per REQ-031 and suppresses frc_done.
REQ-034 SHALL make a force with frc_mask=0 leave act=0 and cnt=0 (no-op visible on q).

Reset
REQ-035 SHALL, when rst=1, immediately set cap=RST_VAL, msk=0, fv=0, cnt=0, act=0, frc_done=0 for all channels, so q=RST_VAL without a clock edge.
REQ-036 SHALL abort any active or timed force on reset with no frc_done pulse; requests sampled while rst=1 are ignored.

Verification
REQ-037 SHALL cover: rst pulse mid-cycle with ch1 forced -> q all channels = RST_VAL before next edge, frc_act=0.
REQ-038 SHALL cover: cap[0]=0x3C, force ch0 mask=0xF0 val=0xA5 len=0 -> q[0]=0xAC next cycle, frc_act[0]=1; en[0] with d=0x11 -> q[0]=0xA1.
REQ-039 SHALL cover: REL_MODE=0, from previous state release ch0 -> q[0] stays 0xA1, frc_act[0]=0; REL_MODE=1 same sequence -> q[0]=0x11.
REQ-040 SHALL cover: force ch2 len=3 mask=0xFF val=0x55 -> q[2]=0x55 for exactly 3 cycles, frc_done[2]=1 for one cycle after expiry edge.
REQ-041 SHALL cover: same-edge force and release on ch3 -> ch3 forced; force ch1 with rel_ch=2 active -> ch1 forced, ch2 released.
REQ-042 SHALL cover: frc_ch=CH (non-power-of-2 CH=3, frc_ch=3) -> no channel state changes.

Source files
------------

// File: rtl/force_reg_bank.sv
// Bank of CH capture registers.
// Any channel can have masked bits overridden, either until released or for a timed number of cycles.
module force_reg_bank #(
    parameter int              WIDTH    = 8,
    parameter int              CH       = 4,
    parameter int              CNT_W    = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              REL_MODE = 0,
    localparam int             CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         en,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic                  frc_req,
    input  logic [CH_W-1:0]       frc_ch,
    input  logic [WIDTH-1:0]      frc_mask,
    input  logic [WIDTH-1:0]      frc_val,
    input  logic [CNT_W-1:0]      frc_len,
    input  logic                  rel_req,
    input  logic [CH_W-1:0]       rel_ch,
    output logic [CH*WIDTH-1:0]   q,
    output logic [CH-1:0]         frc_act,
    output logic [CH-1:0]         frc_done
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [WIDTH-1:0] cap_q, cap_d;
        logic [WIDTH-1:0] msk_q, msk_d;
        logic [WIDTH-1:0] fv_q, fv_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             act_q, act_d;
        logic             done_q, done_d;
        logic [WIDTH-1:0] vis;
        logic             frc_hit, rel_hit, expire, do_rel;

        assign vis = (msk_q & fv_q) | (~msk_q & cap_q);

        // Out-of-range channel numbers never match any i, so those requests fall away here.
        assign frc_hit = frc_req && (frc_ch == CH_W'(i));
        assign rel_hit = rel_req && (rel_ch == CH_W'(i));
        assign expire  = act_q && (cnt_q == CNT_W'(1)) && !frc_hit;
        assign do_rel  = act_q && (rel_hit || expire) && !frc_hit;

        always_comb begin
            cap_d  = cap_q;
            msk_d  = msk_q;
            fv_d   = fv_q;
            cnt_d  = cnt_q;
            act_d  = act_q;
            done_d = expire;
            if (en[i]) begin
                cap_d = d[i*WIDTH +: WIDTH];
            end
            // Keep-mode release folds the visible value into cap so q does not glitch.
            if (do_rel && (REL_MODE == 0)) begin
                cap_d = vis;
            end
            if (frc_hit) begin
                msk_d = frc_mask;
                fv_d  = frc_val;
                act_d = |frc_mask;
                cnt_d = (|frc_mask) ? frc_len : '0;
            end else if (do_rel) begin
                msk_d = '0;
                cnt_d = '0;
                act_d = 1'b0;
            end else if (act_q && (cnt_q > CNT_W'(1))) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cap_q  <= RST_VAL;
                msk_q  <= '0;
                fv_q   <= '0;
                cnt_q  <= '0;
                act_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                cap_q  <= cap_d;
                msk_q  <= msk_d;
                fv_q   <= fv_d;
                cnt_q  <= cnt_d;
                act_q  <= act_d;
                done_q <= done_d;
            end
        end

        assign q[i*WIDTH +: WIDTH] = vis;
        assign frc_act[i]          = act_q;
        assign frc_done[i]         = done_q;
    end

endmodule
